drip_display_scanner: RTL and testbench



---
 rtl/drip_display_pkg.sv | 24 ++
 rtl/drip_bcd_to_seg.sv | 21 ++
 rtl/drip_display_scanner.sv | 138 +++++++++++++
 tb/tb_drip_display_scanner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/drip_display_pkg.sv
// Shared types and constants for the drip counter display scanner:
// scan FSM states and active-high 7-segment patterns ({g,f,e,d,c,b,a}).
package drip_display_pkg;

  typedef enum logic [1:0] {
    S_LATCH,
    S_SHOW,
    S_GUARD
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [2:0] digit_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/drip_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; codes 10-15 show a dash and
// blank_i forces all segments off.
module drip_bcd_to_seg
  import drip_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // NOTE: a default assignment first means every path drives seg_o, so no latch is inferred.
  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (bcd_i <= 4'd9) begin
      seg_o = SEG_DIGITS[bcd_i];
    end
  end

endmodule

// File: rtl/drip_display_scanner.sv
// Time-multiplexed 3-digit 7-segment scanner with per-frame snapshot.
// Optional leading-zero blanking: define DRIP_LEADING_ZERO_BLANK_EN.
module drip_display_scanner
  import drip_display_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int GUARD      = 1,
  parameter int NUM_DIGITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  output logic [6:0] seg,
  output logic [2:0] dig_en,
  output logic       frame_start
);

  localparam int PHASE_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int PW        = $clog2(PHASE_MAX + 1);

  localparam logic [PW-1:0] SHOW_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_LAST = (GUARD > 0) ? PW'(GUARD - 1) : '0;
  localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [2:0][3:0]  snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       dig_en_q, dig_en_d;
  logic             frame_start_q, frame_start_d;

  logic             advance;
  logic [3:0]       cur_digit;
  logic             blank;
  logic [6:0]       dec_seg;

  always_comb begin
    case (idx_q)
      2'd1:    cur_digit = snap_q[1];
      2'd2:    cur_digit = snap_q[2];
      default: cur_digit = snap_q[0];
    endcase
  end

`ifdef DRIP_LEADING_ZERO_BLANK_EN
  // Leading zeros are judged from the frozen snapshot; the units digit always shows.
  assign blank = ((idx_q == 2'd2) && (snap_q[2] == 4'd0)) ||
                 ((idx_q == 2'd1) && (snap_q[2] == 4'd0) && (snap_q[1] == 4'd0));
`else
  assign blank = 1'b0;
`endif

  drip_bcd_to_seg u_dec (
    .bcd_i   (cur_digit),
    .blank_i (blank),
    .seg_o   (dec_seg)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    phase_d       = phase_q;
    snap_d        = snap_q;
    seg_d         = SEG_BLANK;
    dig_en_d      = 3'b000;
    frame_start_d = 1'b0;
    advance       = 1'b0;

    case (state_q)
      S_LATCH: begin
        snap_d        = {digit2, digit1, digit0};
        idx_d         = 2'd0;
        phase_d       = '0;
        frame_start_d = 1'b1;
        state_d       = S_SHOW;
      end
      S_SHOW: begin
        dig_en_d = digit_onehot(idx_q);
        seg_d    = dec_seg;
        if (phase_q == SHOW_LAST) begin
          phase_d = '0;
          if (GUARD > 0) state_d = S_GUARD;
          else           advance = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_GUARD: begin
        if (phase_q == GUARD_LAST) begin
          phase_d = '0;
          advance = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_LATCH;
    endcase

    if (advance) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_LATCH;
      end else begin
        idx_d   = idx_q + 2'd1;
        state_d = S_SHOW;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the snapshot is only three nibbles, so it is reset like any other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_LATCH;
      idx_q         <= 2'd0;
      phase_q       <= '0;
      snap_q        <= '0;
      seg_q         <= SEG_BLANK;
      dig_en_q      <= 3'b000;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      snap_q        <= snap_d;
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_drip_display_scanner.sv
// Directed bench: default scanner (4/1) plus a SCAN_DIV=1, GUARD=0 instance
// sharing clock, reset and digit inputs.
module tb_drip_display_scanner;

  typedef struct {
    logic [3:0] d0, d1, d2;
    logic [6:0] e0, e1, e2;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit0, digit1, digit2;
  logic [6:0] a_seg, b_seg;
  logic [2:0] a_en, b_en;
  logic       a_fs, b_fs;

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs[6];

  always #5 clk = ~clk;

  drip_display_scanner dut_a (
    .clk         (clk),
    .reset       (reset),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .seg         (a_seg),
    .dig_en      (a_en),
    .frame_start (a_fs)
  );

  drip_display_scanner #(.SCAN_DIV(1), .GUARD(0)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .seg         (b_seg),
    .dig_en      (b_en),
    .frame_start (b_fs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the first negedge (after at least one edge) where dut_a's frame_start is high.
  task automatic wait_frame_a();
    int n = 0;
    @(negedge clk);
    while (!a_fs && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame_a", a_fs, 1);
  endtask

  // Checks one full 16-cycle frame of dut_a starting at a frame_start cycle.
  task automatic frame_check_a(input vec_t v, input int chg_k, input logic [3:0] chg_d0,
                               input string tag);
    logic [2:0] exp_en;
    logic [6:0] exp_seg;
    int s, r;
    for (int k = 0; k < 16; k++) begin
      exp_en  = 3'b000;
      exp_seg = 7'h00;
      if (k > 0) begin
        s = (k - 1) / 5;
        r = (k - 1) % 5;
        if (r < 4) begin
          exp_en  = 3'b001 << s;
          exp_seg = (s == 0) ? v.e0 : (s == 1) ? v.e1 : v.e2;
        end
      end
      check($sformatf("%s dig_en k=%0d", tag, k), a_en, exp_en);
      check($sformatf("%s seg k=%0d", tag, k), a_seg, exp_seg);
      check($sformatf("%s frame_start k=%0d", tag, k), a_fs, (k == 0));
      if (k == chg_k) digit0 = chg_d0;
      @(negedge clk);
    end
    check($sformatf("%s frame period", tag), a_fs, 1);
  endtask

  initial begin
    automatic vec_t mv;
    int n;

    vecs[0] = '{4'd7, 4'd2, 4'd3, 7'h07, 7'h5B, 7'h4F};
    vecs[1] = '{4'd0, 4'd1, 4'd9, 7'h3F, 7'h06, 7'h6F};
    vecs[2] = '{4'd4, 4'hC, 4'd8, 7'h66, 7'h40, 7'h7F};
    vecs[3] = '{4'hF, 4'd6, 4'hA, 7'h40, 7'h7D, 7'h40};
`ifdef DRIP_LEADING_ZERO_BLANK_EN
    vecs[4] = '{4'd5, 4'd0, 4'd0, 7'h6D, 7'h00, 7'h00};
    vecs[5] = '{4'd0, 4'd5, 4'd0, 7'h3F, 7'h6D, 7'h00};
`else
    vecs[4] = '{4'd5, 4'd0, 4'd0, 7'h6D, 7'h3F, 7'h3F};
    vecs[5] = '{4'd0, 4'd5, 4'd0, 7'h3F, 7'h6D, 7'h3F};
`endif

    reset  = 1'b1;
    digit0 = 4'd0;
    digit1 = 4'd0;
    digit2 = 4'd0;
    repeat (2) @(negedge clk);
    check("reset seg", a_seg, 7'h00);
    check("reset dig_en", a_en, 3'b000);
    check("reset frame_start", a_fs, 1'b0);
    check("reset b dig_en", b_en, 3'b000);

    reset = 1'b0;
    @(negedge clk);
    check("first edge frame_start", a_fs, 1'b1);
    check("first edge dig_en", a_en, 3'b000);
    @(negedge clk);
    check("second edge dig_en", a_en, 3'b001);

    for (int i = 0; i < 6; i++) begin
      digit0 = vecs[i].d0;
      digit1 = vecs[i].d1;
      digit2 = vecs[i].d2;
      wait_frame_a();
      frame_check_a(vecs[i], -1, 4'd0, $sformatf("vec%0d", i));
    end

    // Units digit changes during the tens slot; the snapshot must hold until the next frame.
    digit0 = 4'd5;
    digit1 = 4'd2;
    digit2 = 4'd3;
    wait_frame_a();
    mv = '{4'd5, 4'd2, 4'd3, 7'h6D, 7'h5B, 7'h4F};
    frame_check_a(mv, 7, 4'd9, "midchg");
    mv = '{4'd9, 4'd2, 4'd3, 7'h6F, 7'h5B, 7'h4F};
    frame_check_a(mv, -1, 4'd0, "after_chg");

    // Asynchronous reset in the middle of the tens slot.
    digit0 = 4'd7;
    wait_frame_a();
    repeat (7) @(negedge clk);
    check("pre-reset dig_en", a_en, 3'b010);
    #1 reset = 1'b1;
    #1;
    check("async reset seg", a_seg, 7'h00);
    check("async reset dig_en", a_en, 3'b000);
    check("async reset frame_start", a_fs, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel first edge frame_start", a_fs, 1'b1);
    check("rel first edge dig_en", a_en, 3'b000);
    @(negedge clk);
    check("rel second edge dig_en", a_en, 3'b001);
    check("rel second edge seg", a_seg, 7'h07);

    // SCAN_DIV=1, GUARD=0 instance: 4-cycle frame, never multi-hot.
    n = 0;
    while (!b_fs && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame_b", b_fs, 1);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b f%0d k%0d dig_en", f, k), b_en, (k == 0) ? 3'b000 : (3'b001 << (k - 1)));
        check($sformatf("b f%0d k%0d seg", f, k), b_seg,
              (k == 0) ? 7'h00 : (k == 1) ? 7'h07 : (k == 2) ? 7'h5B : 7'h4F);
        check($sformatf("b f%0d k%0d frame_start", f, k), b_fs, (k == 0));
        check($sformatf("b f%0d k%0d onehot", f, k), ($countones(b_en) <= 1), 1);
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
